// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer event sequencer: timer register map, CTRL bit layout,
// sequencer FSM states and the timer-bus write beat.
package timer_seq_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_LOAD   = 4'h4;
    localparam logic [3:0] ADDR_VALUE  = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_MODE_BIT     = 1;
    localparam int CTRL_PRESC_EN_BIT = 2;
    localparam int CTRL_DIV_LSB      = 8;
    localparam int CTRL_DIV_MSB      = 15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OFF,
        ST_CLR0,
        ST_LOAD,
        ST_ON,
        ST_WAIT,
        ST_CLR,
        ST_STOP,
        ST_EVT
    } seq_state_e;

    typedef struct packed {
        logic        sel;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } tbus_t;

    // One-shot enable word; mode bit stays 0 so the timer stops itself after one timeout.
    function automatic logic [31:0] ctrl_on_word(input logic [7:0] presc);
        logic [31:0] w;
        w                               = '0;
        w[CTRL_EN_BIT]                  = 1'b1;
        w[CTRL_MODE_BIT]                = 1'b0;
        w[CTRL_PRESC_EN_BIT]            = |presc;
        w[CTRL_DIV_MSB:CTRL_DIV_LSB]    = presc;
        return w;
    endfunction

endpackage

// File: rtl/timer_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x WIDTH, registered full/empty/level; rdata shows the head.
// No bypass: a push becomes visible to the reader one cycle later. Push while full is taken only alongside a pop.
module timer_cmd_fifo #(
    parameter  int WIDTH = 44,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == (AW+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign rdata     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; it is only read while the level says the slot is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/timer_event_sequencer.sv
// Pops delay commands and runs each as a one-shot on the timer bus (OFF,CLR0,LOAD,ON,WAIT,CLR,STOP,EVT); pop-to-OFF 1 cycle, irq-to-event 3 cycles.
// cmd_ready is registered FIFO not-full; events have no backpressure and are at least 4 cycles apart.
module timer_event_sequencer
    import timer_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_delay,
    input  logic [7:0]       cmd_presc,
    input  logic [TAG_W-1:0] cmd_tag,
    input  logic             abort,
    output logic             t_sel,
    output logic             t_we,
    output logic [3:0]       t_addr,
    output logic [31:0]      t_wdata,
    input  logic             t_irq,
    output logic             evt_valid,
    output logic [TAG_W-1:0] evt_tag,
    output logic             evt_aborted,
    output logic             busy,
    output logic [LVL_W-1:0] level
);

    localparam int CMD_W = 32 + 8 + TAG_W;

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [31:0]      r_delay;
    logic [7:0]       r_presc;
    logic [TAG_W-1:0] r_tag;
    logic             r_aborted;

    logic [CMD_W-1:0] w_fifo_dat;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    tbus_t            w_bus;
    logic             w_evt_vld;

    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & ~w_full;
    assign w_pop     = (r_state == ST_IDLE) & ~w_empty;
    assign busy      = (r_state != ST_IDLE);

    timer_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata ({cmd_delay, cmd_presc, cmd_tag}),
        .pop   (w_pop),
        .rdata (w_fifo_dat),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (!w_empty) w_next = ST_OFF;
            ST_OFF:  w_next = ST_CLR0;
            ST_CLR0: w_next = ST_LOAD;
            // A zero load never times out, so skip straight to the completion event.
            ST_LOAD: w_next = (r_delay == 32'd0) ? ST_EVT : ST_ON;
            ST_ON:   w_next = ST_WAIT;
            ST_WAIT: if (abort || t_irq) w_next = ST_CLR;
            ST_CLR:  w_next = ST_STOP;
            ST_STOP: w_next = ST_EVT;
            ST_EVT:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_delay   <= '0;
            r_presc   <= '0;
            r_tag     <= '0;
            r_aborted <= 1'b0;
        end else if (w_pop) begin
            {r_delay, r_presc, r_tag} <= w_fifo_dat;
            r_aborted                 <= 1'b0;
        end else if ((r_state == ST_WAIT) && abort) begin
            r_aborted <= 1'b1;
        end
    end

    always_comb begin
        w_bus     = '0;
        w_evt_vld = 1'b0;
        case (r_state)
            ST_OFF:  w_bus = '{sel: 1'b1, we: 1'b1, addr: ADDR_CTRL,   wdata: 32'd0};
            ST_CLR0: w_bus = '{sel: 1'b1, we: 1'b1, addr: ADDR_STATUS, wdata: 32'd1};
            ST_LOAD: w_bus = '{sel: 1'b1, we: 1'b1, addr: ADDR_LOAD,   wdata: r_delay};
            ST_ON:   w_bus = '{sel: 1'b1, we: 1'b1, addr: ADDR_CTRL,   wdata: ctrl_on_word(r_presc)};
            ST_CLR:  w_bus = '{sel: 1'b1, we: 1'b1, addr: ADDR_STATUS, wdata: 32'd1};
            ST_STOP: w_bus = '{sel: 1'b1, we: 1'b1, addr: ADDR_CTRL,   wdata: 32'd0};
            ST_EVT:  w_evt_vld = 1'b1;
            default: w_bus = '0;
        endcase
    end

    assign t_sel       = w_bus.sel;
    assign t_we        = w_bus.we;
    assign t_addr      = w_bus.addr;
    assign t_wdata     = w_bus.wdata;
    assign evt_valid   = w_evt_vld;
    assign evt_tag     = w_evt_vld ? r_tag : '0;
    assign evt_aborted = w_evt_vld & r_aborted;

endmodule

// File: tb/tb_timer_event_sequencer.sv
// Directed bench: behavioural one-shot timer on the bus, scoreboards for bus writes and events.
module tb_timer_event_sequencer;

    localparam int K_NORM  = 0;
    localparam int K_ABORT = 1;
    localparam int K_KILL  = 2;
    localparam int K_DROP  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_delay;
    logic [7:0]  cmd_presc;
    logic [3:0]  cmd_tag;
    logic        abort;
    logic        t_sel;
    logic        t_we;
    logic [3:0]  t_addr;
    logic [31:0] t_wdata;
    logic        t_irq;
    logic        evt_valid;
    logic [3:0]  evt_tag;
    logic        evt_aborted;
    logic        busy;
    logic [2:0]  level;

    timer_event_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_delay(cmd_delay), .cmd_presc(cmd_presc), .cmd_tag(cmd_tag), .abort(abort),
        .t_sel(t_sel), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata), .t_irq(t_irq),
        .evt_valid(evt_valid), .evt_tag(evt_tag), .evt_aborted(evt_aborted),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural one-shot timer: CTRL en rising reloads, STATUS is write-1-to-clear.
    logic [31:0] tm_ctrl   = '0;
    logic [31:0] tm_load   = '0;
    logic [31:0] tm_cnt    = '0;
    logic [7:0]  tm_pcnt   = '0;
    logic        tm_status = 1'b0;
    assign t_irq = tm_status;

    always @(posedge clk) begin
        if (t_sel && t_we) begin
            case (t_addr)
                4'h0: begin
                    if (t_wdata[0] && !tm_ctrl[0]) begin
                        tm_cnt  <= tm_load;
                        tm_pcnt <= '0;
                    end
                    tm_ctrl <= t_wdata;
                end
                4'h4: tm_load <= t_wdata;
                4'hC: if (t_wdata[0]) tm_status <= 1'b0;
                default: ;
            endcase
        end else if (tm_ctrl[0]) begin
            if (!tm_ctrl[2] || tm_pcnt == tm_ctrl[15:8]) begin
                tm_pcnt <= '0;
                if (tm_cnt != 0) begin
                    tm_cnt <= tm_cnt - 1;
                    if (tm_cnt == 1) begin
                        tm_status  <= 1'b1;
                        tm_ctrl[0] <= 1'b0;
                    end
                end
            end else begin
                tm_pcnt <= tm_pcnt + 8'd1;
            end
        end
    end

    typedef struct { int cyc; logic [3:0] addr; logic [31:0] data; } obs_wr_t;
    typedef struct { int cyc; logic [3:0] tag; logic ab; } obs_evt_t;
    typedef struct packed { logic [3:0] addr; logic [31:0] data; } exp_wr_t;
    typedef struct packed { logic [3:0] tag; logic ab; } exp_evt_t;

    obs_wr_t  obs_wr[$];
    obs_evt_t obs_evt[$];
    int       irq_q[$];
    logic     irq_prev = 1'b0;
    exp_wr_t  exp_wr[$];
    exp_evt_t exp_evt[$];

    always @(negedge clk) begin
        if (t_sel && t_we) obs_wr.push_back('{cyc, t_addr, t_wdata});
        if (evt_valid)     obs_evt.push_back('{cyc, evt_tag, evt_aborted});
        if (t_irq && !irq_prev) irq_q.push_back(cyc);
        irq_prev <= t_irq;
    end

    int errors = 0;
    int checks = 0;
    int rd_w   = 0;
    int rd_e   = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp_v);
        end
    endtask

    task automatic push_cmd(input logic [31:0] d, input logic [7:0] p, input logic [3:0] tg,
                            input int kind, output int acc);
        int n;
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("push_ready_timeout", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_delay = d;
        cmd_presc = p;
        cmd_tag   = tg;
        @(negedge clk);
        acc       = cyc;
        cmd_valid = 1'b0;
        if (kind != K_DROP) begin
            exp_wr.push_back({4'h0, 32'd0});
            exp_wr.push_back({4'hC, 32'd1});
            exp_wr.push_back({4'h4, d});
            if (d != 0) begin
                exp_wr.push_back({4'h0, {16'd0, p, 5'd0, (p != 8'd0), 1'b0, 1'b1}});
                if (kind != K_KILL) begin
                    exp_wr.push_back({4'hC, 32'd1});
                    exp_wr.push_back({4'h0, 32'd0});
                end
            end
            if (kind != K_KILL) exp_evt.push_back({tg, (kind == K_ABORT)});
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(obs_evt.size() >= rd_e + exp_evt.size() && !busy && level == 0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            chk({name, "_evt_timeout"}, obs_evt.size(), rd_e + exp_evt.size());
            chk({name, "_busy_timeout"}, busy, 1'b0);
        end
    endtask

    task automatic drain(input string name);
        exp_wr_t  e;
        exp_evt_t v;
        obs_wr_t  o;
        obs_evt_t q;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            if (rd_w < obs_wr.size()) begin
                o = obs_wr[rd_w];
                chk({name, "_wr"}, {o.addr, o.data}, {e.addr, e.data});
            end else begin
                chk({name, "_wr_missing"}, obs_wr.size(), rd_w + 1);
            end
            rd_w++;
        end
        while (exp_evt.size() > 0) begin
            v = exp_evt.pop_front();
            if (rd_e < obs_evt.size()) begin
                q = obs_evt[rd_e];
                chk({name, "_evt"}, {q.tag, q.ab}, {v.tag, v.ab});
            end else begin
                chk({name, "_evt_missing"}, obs_evt.size(), rd_e + 1);
            end
            rd_e++;
        end
    endtask

    initial begin
        int acc, acc2, bw, be, bi, m, d, n;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_delay = '0;
        cmd_presc = '0;
        cmd_tag   = '0;
        abort     = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_outputs", {t_sel, t_we, t_addr, t_wdata, evt_valid, evt_tag, evt_aborted, busy, level}, '0);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Basic command: write order, pop latency and irq-to-event spacing.
        bw = rd_w; be = rd_e; bi = irq_q.size();
        push_cmd(32'd5, 8'd0, 4'd3, K_NORM, acc);
        chk("basic_level_after_push", level, 3'd1);
        wait_done("basic", 200);
        chk("basic_off_cycle", obs_wr[bw].cyc, acc + 1);
        chk("basic_on_cycle", obs_wr[bw+3].cyc, acc + 4);
        chk("basic_clr_cycle", obs_wr[bw+4].cyc, irq_q[bi] + 1);
        chk("basic_evt_cycle", obs_evt[be].cyc, irq_q[bi] + 3);
        drain("basic");

        // Prescaler divide-by-3.
        bw = rd_w; be = rd_e; bi = irq_q.size();
        push_cmd(32'd3, 8'd2, 4'd5, K_NORM, acc);
        wait_done("presc", 200);
        d = irq_q[bi] - obs_wr[bw+3].cyc;
        chk("presc_irq_delay", (d >= 8 && d <= 11), 1'b1);
        chk("presc_evt_cycle", obs_evt[be].cyc, irq_q[bi] + 3);
        drain("presc");

        // Zero delay: no ON write, event one cycle after LOAD, timer silent.
        bw = rd_w; be = rd_e; bi = irq_q.size();
        push_cmd(32'd0, 8'd1, 4'd7, K_NORM, acc);
        wait_done("zero", 100);
        repeat (30) @(negedge clk);
        chk("zero_evt_cycle", obs_evt[be].cyc, obs_wr[bw+2].cyc + 1);
        chk("zero_no_irq", irq_q.size(), bi);
        drain("zero");

        // Back-pressure: fill the FIFO behind a long command.
        push_cmd(32'd1000, 8'd0, 4'd1, K_NORM, acc);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) push_cmd(32'd2, 8'd0, 4'(i + 2), K_NORM, acc);
        chk("bp_ready_full", cmd_ready, 1'b0);
        chk("bp_level_full", level, 3'd4);
        push_cmd(32'd2, 8'd0, 4'd6, K_NORM, acc);
        wait_done("bp", 3000);
        drain("bp");

        // Abort 50 cycles into WAIT, then the queued command runs normally.
        bw = rd_w; be = rd_e;
        push_cmd(32'd1000, 8'd0, 4'd8, K_ABORT, acc);
        push_cmd(32'd3, 8'd0, 4'd9, K_NORM, acc2);
        while (cyc < acc + 55) @(negedge clk);
        m = cyc;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort", 500);
        chk("abort_clr_cycle", obs_wr[bw+4].cyc, m + 1);
        chk("abort_evt_cycle", obs_evt[be].cyc, m + 3);
        drain("abort");

        // Abort in the same cycle as the first irq sample.
        push_cmd(32'd5, 8'd0, 4'd10, K_ABORT, acc);
        n = 0;
        while (!t_irq && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("simul_irq_timeout", t_irq, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("simul", 200);
        drain("simul");

        // Reset while counting, with one command still queued.
        push_cmd(32'd1000, 8'd0, 4'd11, K_KILL, acc);
        push_cmd(32'd2, 8'd0, 4'd12, K_DROP, acc2);
        while (cyc < acc + 20) @(negedge clk);
        chk("rst_level_before", level, 3'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {t_sel, t_we, t_addr, t_wdata, evt_valid, evt_tag, evt_aborted, busy, level}, '0);
        chk("rst_mid_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        drain("rst_kill");
        bw = rd_w;
        push_cmd(32'd4, 8'd0, 4'd13, K_NORM, acc);
        wait_done("rst_next", 200);
        chk("rst_next_off_cycle", obs_wr[bw].cyc, acc + 1);
        drain("rst_next");

        repeat (5) @(negedge clk);
        chk("extra_writes", obs_wr.size(), rd_w);
        chk("extra_events", obs_evt.size(), rd_e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
